// File: rtl/mimosa_fatigue.sv
// mimosa_fatigue: plant fatigue/rest tracker with AWAKE/TIRED/EXHAUSTED/SLEEPING states.
module mimosa_fatigue #(
  parameter int FATIGUE_LIMIT = 4,
  parameter int TIRED_LIMIT   = 2,
  parameter int REST_LIMIT    = 3,
  parameter int COUNTER_WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stimulus,
  input  logic       reanimated,
  output logic [1:0] state,
  output logic       exhausted
);
  typedef enum logic [1:0] {AWAKE = 2'b00, TIRED = 2'b01, EXHAUSTED = 2'b10, SLEEPING = 2'b11} state_t;
  localparam logic [COUNTER_WIDTH-1:0] FL = FATIGUE_LIMIT[COUNTER_WIDTH-1:0];
  localparam logic [COUNTER_WIDTH-1:0] TL = TIRED_LIMIT[COUNTER_WIDTH-1:0];
  localparam logic [COUNTER_WIDTH-1:0] RL = REST_LIMIT[COUNTER_WIDTH-1:0];
  state_t                   state_q, state_d;
  logic                     exh_q, exh_d;
  logic [COUNTER_WIDTH-1:0] fat_q, fat_d, rest_q, rest_d;
  logic [COUNTER_WIDTH-1:0] rest_inc;
  logic                     rest_done;
  assign rest_inc  = rest_q + 1'b1;
  assign rest_done = rest_inc == RL;
  always_comb begin
    state_d = state_q;
    fat_d   = fat_q;
    rest_d  = rest_q;
    exh_d   = 1'b0;
    case (state_q)
      AWAKE, TIRED: begin
        // Fatigue moves first; the state decision looks at the new value so both land on the same edge.
        if (stimulus) begin
          fat_d  = (fat_q == FL) ? FL : fat_q + 1'b1;
          rest_d = '0;
        end else begin
          rest_d = rest_done ? '0 : rest_inc;
          fat_d  = (rest_done && fat_q != '0) ? fat_q - 1'b1 : fat_q;
        end
        state_d = (fat_d == FL) ? EXHAUSTED : (fat_d >= TL) ? TIRED : AWAKE;
        exh_d   = fat_d == FL;
      end
      EXHAUSTED: begin
        fat_d   = FL;
        rest_d  = (stimulus || rest_done) ? '0 : rest_inc;
        state_d = (!stimulus && rest_done) ? SLEEPING : EXHAUSTED;
      end
      default: begin
        if (reanimated) begin
          state_d = AWAKE;
          fat_d   = '0;
          rest_d  = '0;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= AWAKE;
      exh_q   <= 1'b0;
      fat_q   <= '0;
      rest_q  <= '0;
    end else begin
      state_q <= state_d;
      exh_q   <= exh_d;
      fat_q   <= fat_d;
      rest_q  <= rest_d;
    end
  end
  assign state     = state_q;
  assign exhausted = exh_q;
endmodule

// File: tb/tb_mimosa_fatigue.sv
// tb_mimosa_fatigue: directed vector table plus hand sequences for reset and wake corner cases.
module tb_mimosa_fatigue;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stimulus = 1'b0;
  logic       reanimated = 1'b0;
  logic [1:0] state;
  logic       exhausted;
  int         total = 0;
  int         bad = 0;

  mimosa_fatigue dut (
    .clk(clk), .rst_n(rst_n), .stimulus(stimulus), .reanimated(reanimated),
    .state(state), .exhausted(exhausted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       stim;
    logic       rean;
    logic [1:0] st;
    logic       exh;
  } vec_t;

  vec_t vecs [37];

  task automatic chk(input string name, input logic [1:0] st_exp, input logic exh_exp);
    total++;
    if (state !== st_exp || exhausted !== exh_exp) begin
      bad++;
      $display("FAIL %s: state=%b exhausted=%b, expected state=%b exhausted=%b",
               name, state, exhausted, st_exp, exh_exp);
    end
  endtask

  task automatic step(input logic s, input logic r);
    stimulus   = s;
    reanimated = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stimulus = 1'b0;
    reanimated = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    // Drive to TIRED/EXHAUSTED, rest out to SLEEPING, ignore touches, wake, decay, floor, re-fatigue.
    vecs = '{
      '{1,0,2'b00,0}, '{1,0,2'b01,0}, '{1,0,2'b01,0}, '{1,0,2'b10,1},
      '{0,0,2'b10,0}, '{0,0,2'b10,0}, '{1,0,2'b10,0}, '{0,0,2'b10,0},
      '{0,0,2'b10,0}, '{0,0,2'b11,0},
      '{1,0,2'b11,0}, '{1,0,2'b11,0}, '{1,0,2'b11,0}, '{1,0,2'b11,0}, '{1,0,2'b11,0},
      '{0,1,2'b00,0},
      '{1,0,2'b00,0}, '{1,0,2'b01,0},
      '{0,0,2'b01,0}, '{0,0,2'b01,0}, '{0,0,2'b00,0},
      '{0,0,2'b00,0}, '{0,0,2'b00,0}, '{0,0,2'b00,0},
      '{0,0,2'b00,0}, '{0,0,2'b00,0}, '{0,0,2'b00,0},
      '{1,1,2'b00,0}, '{1,1,2'b01,0},
      '{0,0,2'b01,0}, '{1,0,2'b01,0}, '{0,0,2'b01,0}, '{0,0,2'b01,0}, '{0,0,2'b01,0},
      '{0,0,2'b01,0}, '{1,0,2'b01,0}, '{1,0,2'b10,1}
    };
    #2;
    chk("reset_async", 2'b00, 1'b0);
    do_reset();
    chk("reset_release", 2'b00, 1'b0);
    for (int i = 0; i < 37; i++) begin
      step(vecs[i].stim, vecs[i].rean);
      chk($sformatf("vec%0d", i), vecs[i].st, vecs[i].exh);
    end

    // reanimated held throughout: no effect until SLEEPING, then wake on the next edge
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1);
      chk($sformatf("rean_held_touch%0d", i), (i == 0) ? 2'b00 : (i == 3) ? 2'b10 : 2'b01, i == 3);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      chk($sformatf("rean_held_quiet%0d", i), (i == 2) ? 2'b11 : 2'b10, 1'b0);
    end
    step(1'b0, 1'b1);
    chk("rean_held_wake", 2'b00, 1'b0);

    // asynchronous reset in TIRED with fatigue=3, then full 4 touches needed again
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    chk("pre_reset_tired", 2'b01, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_tired", 2'b00, 1'b0);
    @(posedge clk);
    #1;
    chk("reset_held_ignores", 2'b00, 1'b0);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      chk($sformatf("after_reset_touch%0d", i), (i == 0) ? 2'b00 : (i == 3) ? 2'b10 : 2'b01, i == 3);
    end

    // reset in the middle of the exhausted pulse kills it; nothing after release
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    chk("pulse_present", 2'b10, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("pulse_killed", 2'b00, 1'b0);
    #3;
    rst_n = 1'b1;
    step(1'b0, 1'b0);
    chk("no_pulse_after_release", 2'b00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: run did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mimosa_fatigue.md
MIMOSA_FATIGUE -- requirements
Module: mimosa_fatigue

Interface
REQ-001 Parameter FATIGUE_LIMIT, default 4: fatigue count that forces EXHAUSTED.
REQ-002 Parameter TIRED_LIMIT, default 2: fatigue count at or above which state is TIRED; SHALL satisfy 0 < TIRED_LIMIT < FATIGUE_LIMIT.
REQ-003 Parameter REST_LIMIT, default 3: consecutive quiet cycles needed for one recovery step.
REQ-004 Parameter COUNTER_WIDTH, default 4: width of both counters; SHALL hold max(FATIGUE_LIMIT, REST_LIMIT).
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 stimulus  input  1  touch; each high cycle is one stimulus event.
REQ-008 reanimated  input  1  wake request, only honoured in SLEEPING.
REQ-009 state  output  2  plant state: 00 AWAKE, 01 TIRED, 10 EXHAUSTED, 11 SLEEPING; registered.
REQ-010 exhausted  output  1  one-cycle registered pulse on entry to EXHAUSTED.

Function
REQ-011 Block SHALL hold a fatigue counter (0..FATIGUE_LIMIT) and a rest counter (0..REST_LIMIT).
REQ-012 In AWAKE/TIRED, stimulus=1: fatigue += 1, saturating at FATIGUE_LIMIT; rest counter cleared.
REQ-013 In AWAKE/TIRED, stimulus=0: rest += 1; when rest would reach REST_LIMIT, fatigue -= 1 (floor 0) and rest clears to 0 on the same edge.
REQ-014 State transitions SHALL use the post-edge fatigue value, so counter and state update on the same edge (zero extra latency).
REQ-015 AWAKE -> TIRED when the new fatigue >= TIRED_LIMIT.
REQ-016 TIRED -> AWAKE when the new fatigue < TIRED_LIMIT.
REQ-017 AWAKE or TIRED -> EXHAUSTED when the new fatigue == FATIGUE_LIMIT; this takes priority over REQ-015.
REQ-018 On entry to EXHAUSTED, exhausted SHALL be 1 for exactly the cycle following the transition edge, otherwise 0.
REQ-019 In EXHAUSTED, fatigue holds at FATIGUE_LIMIT.
REQ-020 In EXHAUSTED, stimulus=1 clears rest; stimulus=0 increments rest.
REQ-021 EXHAUSTED -> SLEEPING when rest would reach REST_LIMIT; rest clears on that edge.
REQ-022 In SLEEPING, stimulus SHALL be ignored and counters held.
REQ-023 SLEEPING -> AWAKE on any edge with reanimated=1; fatigue and rest clear to 0 on that edge.
REQ-024 reanimated in AWAKE/TIRED/EXHAUSTED SHALL have no effect.
REQ-025 Illegal or unreachable encodings SHALL not exist: all four codes are legal, and there is no default lock-up.

Reset
REQ-026 rst_n=0 SHALL immediately force state=00 (AWAKE), exhausted=0, fatigue=0, rest=0, regardless of clk.
REQ-027 While rst_n=0, inputs SHALL be ignored; first update on the first rising edge after rst_n deasserts.
REQ-028 Reset mid-EXHAUSTED pulse SHALL kill the pulse at once; no pulse after release.

Verification (defaults: FATIGUE_LIMIT=4, TIRED_LIMIT=2, REST_LIMIT=3)
REQ-029 Reset, then stimulus high 4 cycles -> state 00,01,01,10 after edges 1..4 (TIRED after edge 2); exhausted=1 only after edge 4; fatigue=4.
REQ-030 From TIRED with fatigue=2, stimulus low 3 cycles -> fatigue=1 and state=00 after 3rd edge; low 3 more -> fatigue=0; further quiet cycles keep fatigue=0 (floor).
REQ-031 In EXHAUSTED: quiet 2 cycles, stimulus 1 cycle, quiet 3 cycles -> SLEEPING only after the final 3rd quiet edge; exhausted stays 0 throughout.
REQ-032 In SLEEPING: stimulus high 5 cycles -> state remains 11; then reanimated=1 one cycle -> state=00, fatigue=0 next cycle.
REQ-033 reanimated=1 held during AWAKE->EXHAUSTED sequence -> no effect; if still high when SLEEPING is reached, wake on the next edge.
REQ-034 Assert rst_n=0 asynchronously between edges in TIRED with fatigue=3 -> state=00, exhausted=0 without a clock edge; after release, 4 stimulus cycles are needed to reach EXHAUSTED.
